// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-fed serial program chain loader with generated shift clock
// Optional readback of the chain end is built only when PROG_READBACK_EN is defined.
module prog_loader #(
    parameter int CHAIN_BITS = 12,
    parameter int CLK_DIV    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cfg_data,
    input  logic       cfg_valid,
    input  logic       cfg_last,
    output logic       cfg_ready,
    output logic       prog_in,
    output logic       prog_clk,
    output logic       prog_en,
    input  logic       prog_out,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] rb_data,
    output logic       rb_valid
);
    localparam int CW = $clog2(CHAIN_BITS + 1);
    localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [CW-1:0] CHAIN_N  = CW'(CHAIN_BITS);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_SETUP, S_HIGH, S_DRAIN, S_DONE, S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    byte_q, byte_d;
    logic          last_q, last_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]    div_cnt_q, div_cnt_d;
    logic          cfg_ready_q, cfg_ready_d;
    logic          prog_in_q, prog_in_d;
    logic          prog_clk_q, prog_clk_d;
    logic          prog_en_q, prog_en_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          accept;
    logic          div_end;

    assign accept  = cfg_valid && cfg_ready_q;
    assign div_end = (div_cnt_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        last_d    = last_q;
        bit_idx_d = bit_idx_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (accept) begin
                    byte_d    = cfg_data;
                    last_d    = cfg_last;
                    bit_idx_d = 3'd0;
                    bit_cnt_d = '0;
                    div_cnt_d = 8'd0;
                    state_d   = S_SETUP;
                end
            end
            S_FETCH: begin
                if (accept) begin
                    byte_d    = cfg_data;
                    last_d    = cfg_last;
                    bit_idx_d = 3'd0;
                    div_cnt_d = 8'd0;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                if (div_end) begin
                    div_cnt_d = 8'd0;
                    state_d   = S_HIGH;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            S_HIGH: begin
                if (div_end) begin
                    div_cnt_d = 8'd0;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    // Chain full wins over byte exhaustion: surplus bits of a last byte are dropped.
                    if (bit_cnt_d == CHAIN_N) begin
                        state_d = last_q ? S_DONE : S_DRAIN;
                    end else if (bit_idx_q == 3'd7) begin
                        state_d = last_q ? S_ERR : S_FETCH;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        state_d   = S_SETUP;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            S_DRAIN: begin
                if (accept && cfg_last) state_d = S_ERR;
            end
            default: state_d = S_IDLE;
        endcase

        cfg_ready_d = !(state_d == S_SETUP || state_d == S_HIGH);
        prog_en_d   = (state_d == S_SETUP || state_d == S_HIGH || state_d == S_FETCH);
        prog_clk_d  = (state_d == S_HIGH);
        prog_in_d   = (state_d == S_SETUP || state_d == S_HIGH) ? byte_d[bit_idx_d] : prog_in_q;
        busy_d      = (state_d == S_FETCH || state_d == S_SETUP ||
                       state_d == S_HIGH  || state_d == S_DRAIN);
        done_d      = (state_d == S_DONE);
        err_d       = (state_d == S_ERR);
    end

`ifdef PROG_READBACK_EN
    logic [7:0] rb_shift_q, rb_shift_d;
    logic [2:0] rb_cnt_q, rb_cnt_d;
    logic [7:0] rb_data_q, rb_data_d;
    logic       rb_valid_q, rb_valid_d;
    logic       load_start;
    logic       end_entry;

    assign load_start = (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR) &&
                        (state_d == S_SETUP);
    assign end_entry  = (state_d == S_DONE || state_d == S_ERR) && (state_d != state_q);

    always_comb begin
        rb_shift_d = rb_shift_q;
        rb_cnt_d   = rb_cnt_q;
        rb_data_d  = rb_data_q;
        rb_valid_d = 1'b0;
        if (load_start) begin
            rb_shift_d = 8'd0;
            rb_cnt_d   = 3'd0;
        end else if (state_q == S_SETUP && div_end) begin
            // Sampled one edge before prog_clk rises, so the chain has not yet shifted.
            rb_shift_d[rb_cnt_q] = prog_out;
            if (rb_cnt_q == 3'd7) begin
                rb_data_d  = rb_shift_d;
                rb_valid_d = 1'b1;
                rb_shift_d = 8'd0;
                rb_cnt_d   = 3'd0;
            end else begin
                rb_cnt_d = rb_cnt_q + 3'd1;
            end
        end else if (end_entry && rb_cnt_q != 3'd0) begin
            rb_data_d  = rb_shift_q;
            rb_valid_d = 1'b1;
            rb_shift_d = 8'd0;
            rb_cnt_d   = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_shift_q <= 8'd0;
            rb_cnt_q   <= 3'd0;
            rb_data_q  <= 8'd0;
            rb_valid_q <= 1'b0;
        end else begin
            rb_shift_q <= rb_shift_d;
            rb_cnt_q   <= rb_cnt_d;
            rb_data_q  <= rb_data_d;
            rb_valid_q <= rb_valid_d;
        end
    end

    assign rb_data  = rb_data_q;
    assign rb_valid = rb_valid_q;
`else
    logic unused_prog_out;
    assign unused_prog_out = prog_out;
    assign rb_data  = 8'd0;
    assign rb_valid = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            byte_q      <= 8'd0;
            last_q      <= 1'b0;
            bit_idx_q   <= 3'd0;
            bit_cnt_q   <= '0;
            div_cnt_q   <= 8'd0;
            cfg_ready_q <= 1'b0;
            prog_in_q   <= 1'b0;
            prog_clk_q  <= 1'b0;
            prog_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            last_q      <= last_d;
            bit_idx_q   <= bit_idx_d;
            bit_cnt_q   <= bit_cnt_d;
            div_cnt_q   <= div_cnt_d;
            cfg_ready_q <= cfg_ready_d;
            prog_in_q   <= prog_in_d;
            prog_clk_q  <= prog_clk_d;
            prog_en_q   <= prog_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign prog_in   = prog_in_q;
    assign prog_clk  = prog_clk_q;
    assign prog_en   = prog_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] cfg_data = 8'd0;
    logic       cfg_valid = 1'b0;
    logic       cfg_last = 1'b0;
    logic       cfg_ready, prog_in, prog_clk, prog_en, prog_out;
    logic       busy, done, err, rb_valid;
    logic [7:0] rb_data;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [11:0] chain = 12'h000;
    logic        preload = 1'b0;
    int          edge_cnt = 0;
    logic [31:0] hist = 32'd0;
    int          rb_total = 0;
    logic [15:0] rb_log = 16'd0;

    always #5 clk = ~clk;

    prog_loader dut (
        .clk(clk), .rst_n(rst_n), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
        .cfg_last(cfg_last), .cfg_ready(cfg_ready), .prog_in(prog_in),
        .prog_clk(prog_clk), .prog_en(prog_en), .prog_out(prog_out),
        .busy(busy), .done(done), .err(err), .rb_data(rb_data), .rb_valid(rb_valid)
    );

    // Downstream chain model: shifts toward bit 0, which drives prog_out.
    always @(posedge prog_clk or posedge preload) begin
        if (preload) chain <= 12'h5A5;
        else if (prog_en) chain <= {prog_in, chain[11:1]};
    end
    assign prog_out = chain[0];

    always @(posedge prog_clk) begin
        edge_cnt = edge_cnt + 1;
        hist = {hist[30:0], prog_in};
    end

    always @(negedge clk) begin
        if (rb_valid) begin
            rb_total = rb_total + 1;
            rb_log = {rb_log[7:0], rb_data};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        cfg_data = d; cfg_valid = 1'b1; cfg_last = l;
        while (!cfg_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        cfg_valid = 1'b0; cfg_last = 1'b0;
        if (n >= 2000) chk("send_timeout", 32'(n), 32'd0);
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(done || err) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("end_timeout", 32'(n < 2000), 32'd1);
    endtask

    initial begin
        int base;
        int bad;
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        chk("rst_prog_en",   32'(prog_en),   32'd0);
        chk("rst_prog_clk",  32'(prog_clk),  32'd0);
        chk("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
        rst_n = 1'b1;
        #1 chk("rel_cfg_ready_before_edge", 32'(cfg_ready), 32'd0);
        @(negedge clk);
        chk("rel_cfg_ready_after_edge", 32'(cfg_ready), 32'd1);

        // Exact-length image
        base = edge_cnt;
        send(8'hA5, 1'b0);
        chk("busy_after_first", 32'(busy), 32'd1);
        send(8'h03, 1'b1);
        wait_end();
        chk("exact_edges", 32'(edge_cnt - base), 32'd12);
        chk("exact_seq", {20'd0, hist[11:0]}, 32'h0000_0A5C);
        chk("exact_done_err", {30'd0, done, err}, 32'd2);
        chk("exact_busy_en", {30'd0, busy, prog_en}, 32'd0);

        // Image too short
        base = edge_cnt;
        send(8'hFF, 1'b1);
        wait_end();
        chk("short_edges", 32'(edge_cnt - base), 32'd8);
        chk("short_seq", {24'd0, hist[7:0]}, 32'h0000_00FF);
        chk("short_done_err_en", {29'd0, done, err, prog_en}, 32'd2);

        // Image too long, surplus byte drained
        base = edge_cnt;
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h11, 1'b1);
        wait_end();
        chk("long_edges", 32'(edge_cnt - base), 32'd12);
        chk("long_done_err", {30'd0, done, err}, 32'd1);

        // Source stall between bytes
        base = edge_cnt;
        send(8'hA5, 1'b0);
        n = 0;
        while (!(cfg_ready && prog_en) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("stall_reached_fetch", 32'(n < 2000), 32'd1);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (prog_clk !== 1'b0 || prog_en !== 1'b1) bad++;
        end
        chk("stall_clk_low_en_high", 32'(bad), 32'd0);
        send(8'h03, 1'b1);
        wait_end();
        chk("stall_edges", 32'(edge_cnt - base), 32'd12);
        chk("stall_done_err", {30'd0, done, err}, 32'd2);

        // Reset during the fifth bit's HIGH phase
        base = edge_cnt;
        send(8'hA5, 1'b0);
        n = 0;
        while (!(prog_clk && (edge_cnt - base) == 5) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reached_bit5", 32'(n < 2000), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("mid_rst_outputs", {28'd0, prog_clk, prog_en, busy, cfg_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = edge_cnt;
        send(8'hA5, 1'b0);
        send(8'h03, 1'b1);
        wait_end();
        chk("post_rst_edges", 32'(edge_cnt - base), 32'd12);
        chk("post_rst_seq", {20'd0, hist[11:0]}, 32'h0000_0A5C);
        chk("post_rst_done_err", {30'd0, done, err}, 32'd2);

`ifdef PROG_READBACK_EN
        @(negedge clk);
        preload = 1'b1;
        #1 preload = 1'b0;
        base = rb_total;
        send(8'hA5, 1'b0);
        send(8'h03, 1'b1);
        wait_end();
        repeat (3) @(negedge clk);
        chk("rb_count", 32'(rb_total - base), 32'd2);
        chk("rb_bytes", {16'd0, rb_log}, 32'h0000_A505);
`else
        chk("rb_never_valid", 32'(rb_total), 32'd0);
        chk("rb_data_zero", {24'd0, rb_data}, 32'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
